// File: rtl/br_order_buf.sv
// Branch order buffer: circular queue of predicted branches with RAS pointer and PC snapshots.
// A resolved mispredict squashes younger entries and reports the branch's RAS pointer/PC one cycle later.
module br_order_buf #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int RPTR_W = 4,
    parameter int PC_W   = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alloc_vld_i,
    input  logic [RPTR_W-1:0] alloc_rasptr_i,
    input  logic [PC_W-1:0]   alloc_pc_i,
    output logic              alloc_rdy_o,
    output logic [IDX_W-1:0]  alloc_tag_o,
    input  logic              resolve_vld_i,
    input  logic [IDX_W-1:0]  resolve_tag_i,
    input  logic              resolve_mispred_i,
    input  logic              retire_vld_i,
    output logic              retire_rdy_o,
    output logic              bob_vld_f1r_o,
    output logic [RPTR_W-1:0] bob_rasptr_f1r_o,
    output logic [PC_W-1:0]   bob_pc_f1r_o,
    output logic [IDX_W:0]    count_o
);

    logic [DEPTH-1:0]  valid_r;
    logic [DEPTH-1:0]  resolved_r;
    logic [RPTR_W-1:0] rasptr_r [DEPTH];
    logic [PC_W-1:0]   pc_r     [DEPTH];
    logic [IDX_W-1:0]  head_r;
    logic [IDX_W-1:0]  tail_r;
    logic [IDX_W:0]    count_r;

    logic [IDX_W-1:0]  t_off_s;
    logic              tag_valid_s;
    logic              squash_s;
    logic              alloc_fire_s;
    logic              retire_fire_s;
    logic [DEPTH-1:0]  younger_s;
    logic [IDX_W-1:0]  tail_nxt_s;
    logic [IDX_W:0]    count_nxt_s;

    assign alloc_rdy_o  = (count_r != (IDX_W+1)'(DEPTH));
    assign alloc_tag_o  = tail_r;
    assign retire_rdy_o = (count_r != {(IDX_W+1){1'b0}}) & valid_r[head_r] & resolved_r[head_r];
    assign count_o      = count_r;

    // Fire conditions and age of each entry relative to the resolving branch (age = distance from head).
    always_comb begin
        t_off_s       = resolve_tag_i - head_r;
        tag_valid_s   = valid_r[resolve_tag_i];
        squash_s      = resolve_vld_i & resolve_mispred_i & tag_valid_s;
        alloc_fire_s  = alloc_vld_i & alloc_rdy_o & ~squash_s;
        retire_fire_s = retire_vld_i & retire_rdy_o;
        younger_s     = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            younger_s[i] = (IDX_W'(IDX_W'(i) - head_r) > t_off_s);
        end
    end

    // Next tail and occupancy; a squash rewinds the tail to just past the mispredicting branch.
    always_comb begin
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        if (squash_s) begin
            tail_nxt_s  = resolve_tag_i + IDX_W'(1);
            count_nxt_s = (IDX_W+1)'(t_off_s) + (IDX_W+1)'(1) - (IDX_W+1)'(retire_fire_s);
        end else begin
            tail_nxt_s  = tail_r + IDX_W'(alloc_fire_s);
            count_nxt_s = count_r + (IDX_W+1)'(alloc_fire_s) - (IDX_W+1)'(retire_fire_s);
        end
    end

    // Head, tail and count registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_r  <= {IDX_W{1'b0}};
            tail_r  <= {IDX_W{1'b0}};
            count_r <= {(IDX_W+1){1'b0}};
        end else begin
            head_r  <= head_r + IDX_W'(retire_fire_s);
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Entry storage; allocation never collides with squash (excluded) or retire (different slot).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_r    <= {DEPTH{1'b0}};
            resolved_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rasptr_r[i] <= {RPTR_W{1'b0}};
                pc_r[i]     <= {PC_W{1'b0}};
            end
        end else begin
            if (squash_s) begin
                valid_r <= valid_r & ~younger_s;
            end
            if (resolve_vld_i && tag_valid_s) begin
                resolved_r[resolve_tag_i] <= 1'b1;
            end
            if (alloc_fire_s) begin
                valid_r[tail_r]    <= 1'b1;
                resolved_r[tail_r] <= 1'b0;
                rasptr_r[tail_r]   <= alloc_rasptr_i;
                pc_r[tail_r]       <= alloc_pc_i;
            end
            if (retire_fire_s) begin
                valid_r[head_r] <= 1'b0;
            end
        end
    end

    // Recovery outputs: valid pulses for one cycle, payload holds until the next squash.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bob_vld_f1r_o    <= 1'b0;
            bob_rasptr_f1r_o <= {RPTR_W{1'b0}};
            bob_pc_f1r_o     <= {PC_W{1'b0}};
        end else begin
            bob_vld_f1r_o <= squash_s;
            if (squash_s) begin
                bob_rasptr_f1r_o <= rasptr_r[resolve_tag_i];
                bob_pc_f1r_o     <= pc_r[resolve_tag_i];
            end
        end
    end

endmodule

// File: tb/tb_br_order_buf.sv
// Directed bench for br_order_buf; recovery pulses are checked against a scoreboard queue.
module tb_br_order_buf;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        alloc_vld = 1'b0;
    logic [3:0]  alloc_rasptr = 4'd0;
    logic [63:0] alloc_pc = 64'd0;
    logic        alloc_rdy;
    logic [3:0]  alloc_tag;
    logic        resolve_vld = 1'b0;
    logic [3:0]  resolve_tag = 4'd0;
    logic        resolve_mispred = 1'b0;
    logic        retire_vld = 1'b0;
    logic        retire_rdy;
    logic        bob_vld;
    logic [3:0]  bob_rasptr;
    logic [63:0] bob_pc;
    logic [4:0]  count;

    br_order_buf dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .alloc_vld_i      (alloc_vld),
        .alloc_rasptr_i   (alloc_rasptr),
        .alloc_pc_i       (alloc_pc),
        .alloc_rdy_o      (alloc_rdy),
        .alloc_tag_o      (alloc_tag),
        .resolve_vld_i    (resolve_vld),
        .resolve_tag_i    (resolve_tag),
        .resolve_mispred_i(resolve_mispred),
        .retire_vld_i     (retire_vld),
        .retire_rdy_o     (retire_rdy),
        .bob_vld_f1r_o    (bob_vld),
        .bob_rasptr_f1r_o (bob_rasptr),
        .bob_pc_f1r_o     (bob_pc),
        .count_o          (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  ras;
        logic [63:0] pc;
    } rec_t;

    rec_t        exp_q[$];
    logic [3:0]  m_ras [16];
    logic [63:0] m_pc  [16];
    logic        pend = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          phase = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; recovery pulse must appear exactly when a squash was driven, and match the scoreboard.
    task automatic tick();
        logic pv;
        rec_t e;
        pv   = pend;
        pend = 1'b0;
        @(posedge clock);
        #1;
        chk("bob_vld", {63'd0, bob_vld}, {63'd0, pv});
        if (bob_vld) begin
            if (exp_q.size() == 0) begin
                chk("bob_unexpected_pulse", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("bob_rasptr", {60'd0, bob_rasptr}, {60'd0, e.ras});
                chk("bob_pc", bob_pc, e.pc);
            end
        end else if (pv && exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        pend = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic alloc(input logic [3:0] tag, input logic [3:0] ras, input logic with_retire);
        phase++;
        m_ras[tag]   = ras;
        m_pc[tag]    = {32'hC0DE_0000 + 32'(phase), 28'd0, tag};
        alloc_vld    = 1'b1;
        alloc_rasptr = ras;
        alloc_pc     = m_pc[tag];
        retire_vld   = with_retire;
        tick();
        alloc_vld    = 1'b0;
        retire_vld   = 1'b0;
    endtask

    task automatic resolve(input logic [3:0] tag, input logic mis, input logic expect_squash,
                           input logic with_alloc, input logic with_retire);
        resolve_vld     = 1'b1;
        resolve_tag     = tag;
        resolve_mispred = mis;
        alloc_vld       = with_alloc;
        alloc_rasptr    = 4'hF;
        alloc_pc        = 64'hDEAD_BEEF_0000_0000;
        retire_vld      = with_retire;
        if (expect_squash) begin
            exp_q.push_back('{ras: m_ras[tag], pc: m_pc[tag]});
            pend = 1'b1;
        end
        tick();
        resolve_vld     = 1'b0;
        resolve_mispred = 1'b0;
        alloc_vld       = 1'b0;
        retire_vld      = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_alloc_rdy", 64'(alloc_rdy), 64'd1);
        chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
        chk("rst_retire_rdy", 64'(retire_rdy), 64'd0);
        chk("rst_bob_vld", 64'(bob_vld), 64'd0);
        chk("rst_bob_rasptr", 64'(bob_rasptr), 64'd0);
        chk("rst_bob_pc", bob_pc, 64'd0);

        // Fill to full, then an extra request is dropped
        for (int i = 0; i < 16; i++) begin
            chk("fill_tag", 64'(alloc_tag), 64'(i));
            alloc(4'(i), 4'(i), 1'b0);
        end
        chk("full_count", 64'(count), 64'd16);
        chk("full_rdy", 64'(alloc_rdy), 64'd0);
        alloc_vld = 1'b1;
        tick();
        alloc_vld = 1'b0;
        chk("full_drop_count", 64'(count), 64'd16);
        chk("full_drop_tag", 64'(alloc_tag), 64'd0);

        // Mispredict in the middle of 8 entries
        do_reset();
        for (int i = 0; i < 8; i++) alloc(4'(i), 4'(i + 2), 1'b0);
        chk("eight_count", 64'(count), 64'd8);
        resolve(4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sq3_rasptr_val", 64'(bob_rasptr), 64'd5);
        chk("sq3_count", 64'(count), 64'd4);
        chk("sq3_tag", 64'(alloc_tag), 64'd4);
        tick();
        chk("sq3_hold_rasptr", 64'(bob_rasptr), 64'd5);

        // Mispredict with a same-cycle allocation: allocation discarded
        resolve(4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("sq2_count", 64'(count), 64'd3);
        chk("sq2_tag", 64'(alloc_tag), 64'd3);

        // Retire of unresolved head is ignored; resolve then retire
        chk("unres_retire_rdy", 64'(retire_rdy), 64'd0);
        retire_vld = 1'b1;
        tick();
        retire_vld = 1'b0;
        chk("unres_count", 64'(count), 64'd3);
        resolve(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("res0_retire_rdy", 64'(retire_rdy), 64'd1);
        retire_vld = 1'b1;
        tick();
        retire_vld = 1'b0;
        chk("ret_count", 64'(count), 64'd2);
        chk("ret_head1_unres", 64'(retire_rdy), 64'd0);

        // Mispredict on an invalid tag: no pulse, no change
        resolve(4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("inval_count", 64'(count), 64'd2);
        chk("inval_tag", 64'(alloc_tag), 64'd3);

        // Wrap-around: advance head to 14
        do_reset();
        for (int i = 0; i < 14; i++) begin
            alloc(4'(i), 4'(i), 1'b0);
            resolve(4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            retire_vld = 1'b1;
            tick();
            retire_vld = 1'b0;
        end
        chk("wrap_empty", 64'(count), 64'd0);
        chk("wrap_tag14", 64'(alloc_tag), 64'd14);
        alloc(4'd14, 4'd7, 1'b0);
        alloc(4'd15, 4'd11, 1'b0);
        alloc(4'd0, 4'd13, 1'b0);
        alloc(4'd1, 4'd1, 1'b0);
        chk("wrap_count4", 64'(count), 64'd4);
        chk("wrap_tag2", 64'(alloc_tag), 64'd2);
        resolve(4'd15, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("wrap_sq_rasptr", 64'(bob_rasptr), 64'd11);
        chk("wrap_sq_tail", 64'(alloc_tag), 64'd0);
        chk("wrap_sq_count", 64'(count), 64'd2);

        // Simultaneous alloc and retire keeps count
        resolve(4'd14, 1'b0, 1'b0, 1'b0, 1'b0);
        alloc(4'd0, 4'd3, 1'b1);
        chk("allocret_count", 64'(count), 64'd2);
        chk("allocret_tag", 64'(alloc_tag), 64'd1);

        // Squash at head with same-cycle retire of that head
        chk("head15_rdy", 64'(retire_rdy), 64'd1);
        resolve(4'd15, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("sqhead_count", 64'(count), 64'd0);
        chk("sqhead_tag", 64'(alloc_tag), 64'd0);
        chk("sqhead_retire_rdy", 64'(retire_rdy), 64'd0);
        chk("sqhead_alloc_rdy", 64'(alloc_rdy), 64'd1);

        // Reset mid-fill while a recovery pulse is live
        do_reset();
        for (int i = 0; i < 5; i++) alloc(4'(i), 4'(i + 9), 1'b0);
        resolve(4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("mid_count", 64'(count), 64'd2);
        reset_n = 1'b0;
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_alloc_rdy", 64'(alloc_rdy), 64'd1);
        chk("midrst_alloc_tag", 64'(alloc_tag), 64'd0);
        chk("midrst_bob_vld", 64'(bob_vld), 64'd0);
        chk("midrst_bob_rasptr", 64'(bob_rasptr), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
        chk("post_rst_count", 64'(count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
